// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    // ARM MOV r0,r0
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'hE1A0_0000;

endpackage

// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and instruction memory.
interface fetch_if_id_stage_if;

    logic [31:0] imem_addr_out;
    logic        imem_req_out;
    logic [31:0] imem_data_in;
    logic        imem_ready_in;

    modport master (
        output imem_addr_out,
        output imem_req_out,
        input  imem_data_in,
        input  imem_ready_in
    );

    modport slave (
        input  imem_addr_out,
        input  imem_req_out,
        output imem_data_in,
        output imem_ready_in
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble wins over load, otherwise the slot holds.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (bubble_i) begin
            // pc_plus4 is meaningless in a bubble, so it is left untouched
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction fetch: owns the PC, the imem handshake FSM and a one-entry skid buffer that
// catches a word accepted while decode is stalled; feeds the IF/ID register.
module fetch_if_id_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = DEFAULT_NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       reset,
    fetch_if_id_stage_if.master        imem,
    input  logic                       stall_in,
    input  logic                       flush_in,
    input  logic                       branch_taken_in,
    input  logic [31:0]                branch_target_in,
    output logic [31:0]                if_id_instr_out,
    output logic [31:0]                if_id_pc_plus4_out,
    output logic                       if_id_valid_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc4_q, skid_pc4_d;

    logic         accept;
    logic [31:0]  pc_plus4;
    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  ifid_instr;
    logic [31:0]  ifid_pc4;
    logic         unused_target_lsb;

    assign unused_target_lsb = ^branch_target_in[1:0];

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc_q + 32'(INSTR_BYTES);
    assign accept   = (state_q == FETCH) && imem.imem_ready_in;

    assign imem.imem_addr_out = pc_q;
    assign imem.imem_req_out  = (state_q == FETCH);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_instr   = imem.imem_data_in;
        ifid_pc4     = pc_plus4;

        if (branch_taken_in) begin
            // Any same-cycle fetch is dropped; leaving HOLD discards the skid entry.
            pc_d        = {branch_target_in[31:2], 2'b00};
            ifid_bubble = 1'b1;
            state_d     = FETCH;
        end else if (flush_in) begin
            // PC is not rewound: a dropped skid entry was already counted in the PC.
            state_d = FETCH;
            if (accept && !stall_in) begin
                pc_d      = pc_plus4;
                ifid_load = 1'b1;
            end else begin
                ifid_bubble = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (accept) begin
                        pc_d = pc_plus4;
                        if (stall_in) begin
                            skid_instr_d = imem.imem_data_in;
                            skid_pc4_d   = pc_plus4;
                            state_d      = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall_in) begin
                        ifid_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        ifid_load  = 1'b1;
                        ifid_instr = skid_instr_q;
                        ifid_pc4   = skid_pc4_q;
                        state_d    = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .instr_i    (ifid_instr),
        .pc_plus4_i (ifid_pc4),
        .instr_o    (if_id_instr_out),
        .pc_plus4_o (if_id_pc_plus4_out),
        .valid_o    (if_id_valid_out)
    );

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Bench for fetch_if_id_stage: queue-based model checked every cycle plus directed literal checks.
module tb_fetch_if_id_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] target = 32'h0;
    logic        ready = 1'b1;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int tests = 0;
    int fails = 0;

    fetch_if_id_stage_if imem ();

    // Memory returns address + 0x100 for whatever address is presented.
    assign imem.imem_data_in  = imem.imem_addr_out + 32'h100;
    assign imem.imem_ready_in = ready;

    fetch_if_id_stage #(
        .RESET_VECTOR (32'h0000_0000),
        .NOP_INSTR    (NOP)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .imem               (imem),
        .stall_in           (stall),
        .flush_in           (flush),
        .branch_taken_in    (branch),
        .branch_target_in   (target),
        .if_id_instr_out    (if_id_instr),
        .if_id_pc_plus4_out (if_id_pc4),
        .if_id_valid_out    (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of words fetched but not yet handed to decode, plus the decode slot.
    word_t       m_buf[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;
    bit          m_started;

    function automatic bit m_req();
        return m_started && (m_buf.size() == 0);
    endfunction

    task automatic m_take(input word_t w);
        m_instr = w.instr;
        m_pc4   = w.pc4;
        m_valid = 1'b1;
    endtask

    task automatic m_bubble();
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        bit    fetched;
        word_t w;
        if (!reset) begin
            m_pc      = 32'h0;
            m_buf.delete();
            m_instr   = NOP;
            m_pc4     = 32'h0;
            m_valid   = 1'b0;
            m_started = 1'b0;
            return;
        end
        fetched = m_req() && ready;
        w.instr = m_pc + 32'h100;
        w.pc4   = m_pc + 32'd4;
        if (branch) begin
            m_pc = target & 32'hFFFF_FFFC;
            m_buf.delete();
            m_bubble();
            m_started = 1'b1;
        end else if (flush) begin
            m_buf.delete();
            m_started = 1'b1;
            if (fetched && !stall) begin
                m_take(w);
                m_pc = m_pc + 32'd4;
            end else begin
                m_bubble();
            end
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (!stall) begin
            if (m_buf.size() != 0) begin
                m_take(m_buf.pop_front());
            end else if (fetched) begin
                m_take(w);
                m_pc = m_pc + 32'd4;
            end else begin
                m_bubble();
            end
        end else if (fetched) begin
            m_buf.push_back(w);
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk or negedge reset);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("model addr", imem.imem_addr_out, m_pc);
                check("model req", 32'(imem.imem_req_out), 32'(m_req()));
                check("model valid", 32'(if_id_valid), 32'(m_valid));
                check("model instr", if_id_instr, m_instr);
                if (m_valid) check("model pc4", if_id_pc4, m_pc4);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                       input logic valid);
        check({tag, " instr"}, if_id_instr, instr);
        check({tag, " valid"}, 32'(if_id_valid), 32'(valid));
        if (valid) check({tag, " pc4"}, if_id_pc4, pc4);
    endtask

    initial begin
        cyc(2);
        lit("reset", NOP, 32'h0, 1'b0);
        check("reset pc4", if_id_pc4, 32'h0);
        check("reset req", 32'(imem.imem_req_out), 32'h0);
        check("reset addr", imem.imem_addr_out, 32'h0);

        reset = 1'b1;
        cyc(1);
        check("idle->fetch req", 32'(imem.imem_req_out), 32'h1);
        lit("first fetch pending", NOP, 32'h0, 1'b0);
        cyc(1);
        lit("seq0", 32'h100, 32'h4, 1'b1);
        cyc(1);
        lit("seq1", 32'h104, 32'h8, 1'b1);

        // Stall three cycles with PC=8: 0x108 parks in the skid.
        stall = 1'b1;
        cyc(1);
        check("hold req", 32'(imem.imem_req_out), 32'h0);
        check("hold addr", imem.imem_addr_out, 32'hC);
        lit("hold slot", 32'h104, 32'h8, 1'b1);
        cyc(2);
        check("hold addr late", imem.imem_addr_out, 32'hC);
        stall = 1'b0;
        cyc(1);
        lit("skid drain", 32'h108, 32'hC, 1'b1);
        check("skid drain req", 32'(imem.imem_req_out), 32'h1);
        cyc(1);
        lit("after skid", 32'h10C, 32'h10, 1'b1);

        // Branch beats a same-cycle stall and accept; target LSBs are dropped.
        branch = 1'b1;
        target = 32'h0000_0043;
        stall  = 1'b1;
        cyc(1);
        check("branch addr", imem.imem_addr_out, 32'h40);
        lit("branch bubble", NOP, 32'h0, 1'b0);
        branch = 1'b0;
        stall  = 1'b0;
        cyc(1);
        lit("branch target", 32'h140, 32'h44, 1'b1);

        // Memory wait states at PC=0x20.
        branch = 1'b1;
        target = 32'h0000_0020;
        cyc(1);
        branch = 1'b0;
        ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("wait addr", imem.imem_addr_out, 32'h20);
            lit("wait bubble", NOP, 32'h0, 1'b0);
        end
        ready = 1'b1;
        cyc(1);
        lit("wait done", 32'h120, 32'h24, 1'b1);

        // Flush with stall drops the same-cycle fetch and keeps the PC.
        flush = 1'b1;
        stall = 1'b1;
        cyc(1);
        check("flush stall addr", imem.imem_addr_out, 32'h24);
        lit("flush stall", NOP, 32'h0, 1'b0);
        flush = 1'b0;
        cyc(1);
        check("hold2 addr", imem.imem_addr_out, 32'h28);
        // Flush while holding 0x124 in the skid.
        flush = 1'b1;
        cyc(1);
        lit("flush hold", NOP, 32'h0, 1'b0);
        check("flush hold req", 32'(imem.imem_req_out), 32'h1);
        check("flush hold addr", imem.imem_addr_out, 32'h28);
        flush = 1'b0;
        stall = 1'b0;
        cyc(1);
        lit("after flush", 32'h128, 32'h2C, 1'b1);
        // Flush without stall still takes the same-cycle fetch.
        flush = 1'b1;
        cyc(1);
        lit("flush accept", 32'h12C, 32'h30, 1'b1);
        check("flush accept addr", imem.imem_addr_out, 32'h30);
        flush = 1'b0;

        // PC wrap at the top of the address space.
        branch = 1'b1;
        target = 32'hFFFF_FFFF;
        cyc(1);
        check("wrap addr", imem.imem_addr_out, 32'hFFFF_FFFC);
        branch = 1'b0;
        cyc(1);
        lit("wrap", 32'h0000_00FC, 32'h0, 1'b1);
        check("wrap next addr", imem.imem_addr_out, 32'h0);

        // Asynchronous reset mid-HOLD.
        stall = 1'b1;
        cyc(1);
        check("pre-reset req", 32'(imem.imem_req_out), 32'h0);
        #2;
        reset = 1'b0;
        #1;
        lit("async reset", NOP, 32'h0, 1'b0);
        check("async reset pc4", if_id_pc4, 32'h0);
        check("async reset req", 32'(imem.imem_req_out), 32'h0);
        check("async reset addr", imem.imem_addr_out, 32'h0);
        cyc(1);
        reset = 1'b1;
        stall = 1'b0;
        cyc(2);
        lit("restart", 32'h100, 32'h4, 1'b1);
        cyc(2);
        lit("restart2", 32'h108, 32'hC, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
